data_stream_burst_sched: RTL and testbench



---
 rtl/data_stream_burst_sched.sv | 192 +++++++++++++++++++
 tb/tb_data_stream_burst_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_stream_burst_sched.sv
// Sequences one packet generator through a list of NoC destinations, one fixed-length burst per entry.
// Latency: i_go edge -> o_busy/o_gen_start two cycles later; final burst beat -> o_gen_start low next cycle.
// Backpressure: only beats with valid & ready count toward a burst; a stalled generator simply lengthens the burst.
module data_stream_burst_sched #(
    parameter int NUM_DEST = 4,
    parameter int BURST_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_go,
    input  logic                  i_stop,
    input  logic                  i_loop,
    input  logic [4:0]            i_num_dests,
    input  logic [NUM_DEST*4-1:0] i_dest_list,
    input  logic [BURST_W-1:0]    i_burst_len,
    input  logic [7:0]            i_gap_cycles,
    input  logic                  i_beat_valid,
    input  logic                  i_beat_ready,
    output logic                  o_gen_start,
    output logic                  o_gen_enable,
    output logic [3:0]            o_dest_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic [3:0]            o_cur_idx,
    output logic [31:0]           o_total_beats,
    output logic [15:0]           o_overrun_beats
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t               state;
    logic                 go_q;
    logic                 go_rise;
    logic                 abort_flag;
    logic                 drain_low;
    logic [BURST_W-1:0]   beat_cnt;
    logic [7:0]           gap_cnt;

    logic                 beat;
    logic [4:0]           eff_dests;
    logic [4:0]           last_idx;
    logic                 is_last;
    logic [3:0]           next_idx;
    logic [BURST_W-1:0]   eff_burst;
    logic [7:0]           eff_gap;

    // Destination nibble for list entry k.
    function automatic logic [3:0] dest_at(input logic [NUM_DEST*4-1:0] lst, input logic [3:0] k);
        return lst[4*int'(k) +: 4];
    endfunction

    // Effective (clamped) configuration and next-index arithmetic.
    always_comb begin
        beat = i_beat_valid & i_beat_ready;

        if (i_num_dests == 5'd0) begin
            eff_dests = 5'd1;
        end else if (i_num_dests > 5'(NUM_DEST)) begin
            eff_dests = 5'(NUM_DEST);
        end else begin
            eff_dests = i_num_dests;
        end
        last_idx = eff_dests - 5'd1;
        is_last  = ({1'b0, o_cur_idx} == last_idx);
        next_idx = is_last ? 4'd0 : (o_cur_idx + 4'd1);

        eff_burst = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
        eff_gap   = (i_gap_cycles < 8'd2) ? 8'd2 : i_gap_cycles;
    end

    // Registered rising-edge detect on i_go. go_q resets high so a level held
    // through reset must drop and rise again before it starts a sequence.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            go_q    <= 1'b1;
            go_rise <= 1'b0;
        end else begin
            go_q    <= i_go;
            go_rise <= i_go & ~go_q;
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= S_IDLE;
            abort_flag      <= 1'b0;
            drain_low       <= 1'b0;
            beat_cnt        <= '0;
            gap_cnt         <= '0;
            o_gen_start     <= 1'b0;
            o_gen_enable    <= 1'b0;
            o_dest_addr     <= 4'd0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_aborted       <= 1'b0;
            o_cur_idx       <= 4'd0;
            o_total_beats   <= 32'd0;
            o_overrun_beats <= 16'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_rise) begin
                        state           <= S_BURST;
                        abort_flag      <= 1'b0;
                        beat_cnt        <= '0;
                        o_gen_start     <= 1'b1;
                        o_gen_enable    <= 1'b1;
                        o_busy          <= 1'b1;
                        o_aborted       <= 1'b0;
                        o_cur_idx       <= 4'd0;
                        o_dest_addr     <= dest_at(i_dest_list, 4'd0);
                        o_total_beats   <= 32'd0;
                        o_overrun_beats <= 16'd0;
                    end
                end

                S_BURST: begin
                    // A stop request only marks the sequence; the burst in flight finishes.
                    if (i_stop) begin
                        abort_flag <= 1'b1;
                    end
                    if (beat) begin
                        o_total_beats <= o_total_beats + 32'd1;
                        if (beat_cnt + BURST_W'(1) == eff_burst) begin
                            state        <= S_DRAIN;
                            drain_low    <= 1'b0;
                            o_gen_start  <= 1'b0;
                            o_gen_enable <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + BURST_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    // Beats the generator still pushes after enable drops are overrun.
                    if (beat) begin
                        o_total_beats <= o_total_beats + 32'd1;
                        if (o_overrun_beats != 16'hFFFF) begin
                            o_overrun_beats <= o_overrun_beats + 16'd1;
                        end
                    end
                    if (!i_beat_valid) begin
                        if (drain_low) begin
                            state   <= S_GAP;
                            gap_cnt <= eff_gap - 8'd1;
                        end else begin
                            drain_low <= 1'b1;
                        end
                    end else begin
                        drain_low <= 1'b0;
                    end
                end

                S_GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else if (abort_flag) begin
                        state     <= S_IDLE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_aborted <= 1'b1;
                    end else if ((is_last && !i_loop) || i_stop) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        state        <= S_BURST;
                        beat_cnt     <= '0;
                        o_cur_idx    <= next_idx;
                        o_dest_addr  <= dest_at(i_dest_list, next_idx);
                        o_gen_start  <= 1'b1;
                        o_gen_enable <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_stream_burst_sched.sv
// Bench for data_stream_burst_sched: acts as the generator and compares against a transaction-level model.
// Latency: checks go->start spacing and start-low spacing between bursts.
// Backpressure: ready and valid are randomised; burst lengths are checked in accepted beats.
module tb_data_stream_burst_sched;
    localparam int NUM_DEST = 4;
    localparam int BURST_W  = 16;

    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_go = 1'b0;
    logic                  i_stop = 1'b0;
    logic                  i_loop = 1'b0;
    logic [4:0]            i_num_dests = 5'd1;
    logic [NUM_DEST*4-1:0] i_dest_list = '0;
    logic [BURST_W-1:0]    i_burst_len = 16'd1;
    logic [7:0]            i_gap_cycles = 8'd2;
    logic                  i_beat_valid = 1'b0;
    logic                  i_beat_ready = 1'b0;
    logic                  o_gen_start, o_gen_enable, o_busy, o_done, o_aborted;
    logic [3:0]            o_dest_addr, o_cur_idx;
    logic [31:0]           o_total_beats;
    logic [15:0]           o_overrun_beats;

    always #5 clk = ~clk;

    data_stream_burst_sched #(.NUM_DEST(NUM_DEST), .BURST_W(BURST_W)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_go(i_go), .i_stop(i_stop), .i_loop(i_loop),
        .i_num_dests(i_num_dests), .i_dest_list(i_dest_list), .i_burst_len(i_burst_len),
        .i_gap_cycles(i_gap_cycles), .i_beat_valid(i_beat_valid), .i_beat_ready(i_beat_ready),
        .o_gen_start(o_gen_start), .o_gen_enable(o_gen_enable), .o_dest_addr(o_dest_addr),
        .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_cur_idx(o_cur_idx),
        .o_total_beats(o_total_beats), .o_overrun_beats(o_overrun_beats)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Generator model: random valid while enabled, then holds valid for a chosen trail length.
    int ready_pct = 100;
    int valid_pct = 100;
    int trail_min = 0;
    int trail_max = 0;
    int trail = 0;
    bit prev_en = 1'b0;
    int q_k[$];

    always @(posedge clk) begin
        #1;
        if (prev_en && !o_gen_enable) begin
            trail = int'($urandom_range(trail_max, trail_min));
            q_k.push_back(trail);
        end
        prev_en = o_gen_enable;
        if (o_gen_enable) begin
            i_beat_valid = (int'($urandom_range(99, 0)) < valid_pct);
        end else if (trail > 0) begin
            i_beat_valid = 1'b1;
            trail--;
        end else begin
            i_beat_valid = 1'b0;
        end
        i_beat_ready = (int'($urandom_range(99, 0)) < ready_pct);
    end

    // Observation model: bursts are the intervals with start high.
    int     q_dest[$], q_idx[$], q_beats[$], q_low[$];
    int     cur_beats = 0, low_len = 0, done_cnt = 0, done_bad = 0, dest_chg = 0, en_bad = 0;
    int     exp_over = 0;
    longint exp_total = 0;
    logic [3:0] cur_dest = 4'd0;
    bit     p_start = 1'b0, p_busy = 1'b0;

    always @(negedge clk) begin
        bit hs;
        hs = i_beat_valid && i_beat_ready;
        if (o_gen_start && !p_start) begin
            if (q_dest.size() > 0) q_low.push_back(low_len);
            q_dest.push_back(int'(o_dest_addr));
            q_idx.push_back(int'(o_cur_idx));
            cur_dest  = o_dest_addr;
            cur_beats = 0;
        end
        if (o_gen_start) begin
            if (o_dest_addr !== cur_dest) dest_chg++;
            if (hs) begin
                cur_beats++;
                exp_total++;
            end
        end else begin
            if (p_start) begin
                q_beats.push_back(cur_beats);
                low_len = 0;
            end
            if (o_busy) begin
                low_len++;
                if (hs) begin
                    exp_total++;
                    exp_over++;
                end
            end
        end
        if (o_gen_enable !== o_gen_start) en_bad++;
        if (o_done) begin
            done_cnt++;
            if (!(p_busy && !o_busy)) done_bad++;
        end
        p_start = o_gen_start;
        p_busy  = o_busy;
    end

    task automatic clear_model();
        q_dest.delete(); q_idx.delete(); q_beats.delete(); q_low.delete(); q_k.delete();
        cur_beats = 0; low_len = 0; done_cnt = 0; done_bad = 0; dest_chg = 0; en_bad = 0;
        exp_over = 0; exp_total = 0;
    endtask

    task automatic run_seq(input string tag, input int n, input logic [15:0] list, input int blen,
                           input int gap, input bit loop, input int stop_at, input int rpct,
                           input int vpct, input int tmin, input int tmax);
        int eff_n, eff_b, eff_g, nb_exp, lat, cyc;
        bit stopped, regoed;
        eff_n  = (n == 0) ? 1 : ((n > NUM_DEST) ? NUM_DEST : n);
        eff_b  = (blen == 0) ? 1 : blen;
        eff_g  = (gap < 2) ? 2 : gap;
        nb_exp = (stop_at > 0) ? stop_at : eff_n;
        @(posedge clk); #1;
        i_num_dests = 5'(n); i_dest_list = list; i_burst_len = 16'(blen);
        i_gap_cycles = 8'(gap); i_loop = loop;
        ready_pct = rpct; valid_pct = vpct; trail_min = tmin; trail_max = tmax;
        clear_model();
        i_go = 1'b1;
        lat = 0;
        while (!o_gen_start && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_eq({tag, ".go_lat"}, 64'(lat), 64'd2);
        cyc = 0; stopped = 0; regoed = 0;
        while (done_cnt == 0 && !(o_done) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) i_go = 1'b0;
            if (regoed && i_go) i_go = 1'b0;
            else if (!regoed && cyc >= 6 && o_gen_start) begin
                i_go = 1'b1;
                regoed = 1;
            end
            if (stop_at > 0 && !stopped && q_dest.size() == stop_at && o_gen_start) begin
                i_stop  = 1'b1;
                stopped = 1;
            end
        end
        i_go = 1'b0;
        chk_eq({tag, ".done_seen"}, 64'(cyc < 20000), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        i_stop = 1'b0;
        chk_eq({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        chk_eq({tag, ".busy_end"}, 64'(o_busy), 64'd0);
        chk_eq({tag, ".nbursts"}, 64'(q_dest.size()), 64'(nb_exp));
        for (int i = 0; i < q_dest.size() && i < nb_exp; i++) begin
            chk_eq({tag, ".dest"}, 64'(q_dest[i]), 64'(list[4*(i % eff_n) +: 4]));
            chk_eq({tag, ".idx"}, 64'(q_idx[i]), 64'(i % eff_n));
            if (i < q_beats.size()) chk_eq({tag, ".beats"}, 64'(q_beats[i]), 64'(eff_b));
        end
        for (int i = 0; i < q_low.size() && i < q_k.size(); i++) begin
            chk_eq({tag, ".spacing"}, 64'(q_low[i]), 64'(q_k[i] + 2 + eff_g));
        end
        chk_eq({tag, ".total"}, 64'(o_total_beats), 64'(exp_total[31:0]));
        chk_eq({tag, ".overrun"}, 64'(o_overrun_beats), 64'(exp_over));
        chk_eq({tag, ".aborted"}, 64'(o_aborted), 64'(stop_at > 0));
        chk_eq({tag, ".done_busy"}, 64'(done_bad), 64'd0);
        chk_eq({tag, ".dest_stable"}, 64'(dest_chg), 64'd0);
        chk_eq({tag, ".enable"}, 64'(en_bad), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk_eq("reset.outputs", 64'({o_gen_start, o_gen_enable, o_dest_addr, o_busy, o_done,
                                     o_aborted, o_cur_idx, o_total_beats, o_overrun_beats}), 64'd0);
        repeat (3) @(posedge clk);

        // Three destinations, ready always high, random drain trails.
        run_seq("basic", 3, 16'h0952, 4, 3, 1'b0, 0, 100, 100, 0, 3);
        // Ready toggling ~50% with burst length 8.
        run_seq("ready50", 2, 16'h00A7, 8, 5, 1'b0, 0, 50, 100, 0, 2);
        // Zero config values: one beat, gap of 2, single destination.
        run_seq("zeros", 0, 16'h4321, 0, 0, 1'b0, 0, 100, 100, 0, 0);
        // Looping with stop during the idx 1 burst.
        run_seq("stop1", 2, 16'h00C3, 5, 2, 1'b1, 2, 100, 100, 0, 1);
        // Looping with stop after wrapping back to entry 0.
        run_seq("stopwrap", 2, 16'h00E6, 3, 4, 1'b1, 3, 70, 80, 0, 2);
        // Generator holds valid three cycles past start falling.
        run_seq("trail3", 1, 16'h000B, 5, 4, 1'b0, 0, 100, 100, 3, 3);
        chk_eq("trail3.overrun_fixed", 64'(o_overrun_beats), 64'd3);
        // num_dests above NUM_DEST clamps.
        run_seq("clamp", 20, 16'hFEDC, 2, 2, 1'b0, 0, 100, 100, 0, 1);

        // Reset mid-burst with i_go held high.
        @(posedge clk); #1;
        i_num_dests = 5'd2; i_dest_list = 16'h0081; i_burst_len = 16'd6;
        i_gap_cycles = 8'd3; i_loop = 1'b1; ready_pct = 100; valid_pct = 100;
        trail_min = 0; trail_max = 0;
        i_go = 1'b1;
        for (int w = 0; w < 20 && !o_gen_start; w++) begin
            @(posedge clk); #1;
        end
        chk_eq("rst.started", 64'(o_gen_start), 64'd1);
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        chk_eq("rst.outputs", 64'({o_gen_start, o_gen_enable, o_dest_addr, o_busy, o_done,
                                   o_aborted, o_cur_idx, o_total_beats, o_overrun_beats}), 64'd0);
        i_reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_eq("rst.no_restart", 64'(o_busy), 64'd0);
        i_go = 1'b0;
        repeat (4) @(posedge clk);
        run_seq("after_rst", 2, 16'h0081, 3, 2, 1'b0, 0, 100, 100, 0, 1);

        // Randomised configurations, some ending via stop.
        for (int r = 0; r < 6; r++) begin
            bit lp;
            int sa;
            lp = (r % 3 == 2);
            sa = lp ? int'($urandom_range(4, 1)) : 0;
            run_seq("rand", int'($urandom_range(6, 0)), 16'($urandom), int'($urandom_range(10, 0)),
                    int'($urandom_range(6, 0)), lp, sa, ((r % 2) == 0) ? 50 : 100,
                    ((r % 2) == 0) ? 100 : 70, 0, 3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
